// File: rtl/stack_access_arbiter.sv
// rtl/stack_access_arbiter.sv - round-robin two-requester front end for a shared synchronous-read stack memory
//
// Purpose:
//   Requesters A and B issue push/pop operations over valid/ready. One
//   operation is in flight at a time. The block grants round-robin, drives
//   the external stack memory, keeps the stack pointer and occupancy, and
//   returns a one-cycle response pulse to the requester that owned the op.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_{a,b}_valid/op/data/ready      request handshake (op 0 = push, 1 = pop)
//   rsp_{a,b}_valid/data/err           one-cycle completion pulse per requester
//   mem_we/mem_addr/mem_wdata          memory write/address/write-data
//   mem_rdata                          memory read data, one cycle after mem_addr
//   count/full/empty                   registered occupancy and flags

module stack_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256  // must be 2**ADDR_W so sp wraps exactly at full
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_a_valid,
  input  logic              req_a_op,
  input  logic [DATA_W-1:0] req_a_data,
  output logic              req_a_ready,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_data,
  output logic              rsp_a_err,

  input  logic              req_b_valid,
  input  logic              req_b_op,
  input  logic [DATA_W-1:0] req_b_data,
  output logic              req_b_ready,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_data,
  output logic              rsp_b_err,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic  OP_PUSH  = 1'b0;
  localparam logic  OP_POP   = 1'b1;
  localparam logic  SEL_A    = 1'b0;
  localparam logic  SEL_B    = 1'b1;
  localparam cnt_t  CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t  CNT_ONE  = cnt_t'(1);
  localparam addr_t ADDR_ONE = addr_t'(1);

  state_t              state_q, state_d;
  addr_t               sp_q;
  cnt_t                count_q;
  logic                full_q, empty_q;
  logic                last_grant_q;
  logic                owner_q;
  logic                op_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;

  // Acceptance-time values, valid only while accept is high.
  logic                grant_a, grant_b;
  logic                accept;
  logic                acc_owner;
  logic                acc_op;
  logic [DATA_W-1:0]   acc_data;
  logic                acc_err;
  logic [DATA_W-1:0]   rsp_data_sel;

  // A lone requester always wins; under contention the one that was not
  // granted last time wins.
  assign grant_a = req_a_valid && (!req_b_valid || (last_grant_q == SEL_B));
  assign grant_b = req_b_valid && (!req_a_valid || (last_grant_q == SEL_A));

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

  always_comb begin
    state_d      = state_q;
    req_a_ready  = 1'b0;
    req_b_ready  = 1'b0;
    rsp_a_valid  = 1'b0;
    rsp_a_data   = '0;
    rsp_a_err    = 1'b0;
    rsp_b_valid  = 1'b0;
    rsp_b_data   = '0;
    rsp_b_err    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    accept       = 1'b0;
    acc_owner    = SEL_A;
    acc_op       = OP_PUSH;
    acc_data     = '0;
    acc_err      = 1'b0;
    rsp_data_sel = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          accept      = 1'b1;
          acc_owner   = grant_b ? SEL_B : SEL_A;
          req_a_ready = grant_a;
          req_b_ready = grant_b;
          acc_op      = grant_b ? req_b_op   : req_a_op;
          acc_data    = grant_b ? req_b_data : req_a_data;
          // Rejected ops skip the memory step and answer on the next cycle.
          acc_err     = (acc_op == OP_PUSH) ? full_q : empty_q;
          if (acc_err) begin
            state_d = S_RESP;
          end else if (acc_op == OP_POP) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = data_q;
        state_d   = S_RESP;
      end

      S_READ: begin
        // Top of stack lives one below sp; the read data lands in RESP.
        mem_addr = sp_q - ADDR_ONE;
        state_d  = S_RESP;
      end

      S_RESP: begin
        if ((op_q == OP_POP) && !err_q) begin
          rsp_data_sel = mem_rdata;
        end
        if (owner_q == SEL_B) begin
          rsp_b_valid = 1'b1;
          rsp_b_data  = rsp_data_sel;
          rsp_b_err   = err_q;
        end else begin
          rsp_a_valid = 1'b1;
          rsp_a_data  = rsp_data_sel;
          rsp_a_err   = err_q;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      last_grant_q <= SEL_B;
      owner_q      <= SEL_A;
      op_q         <= OP_PUSH;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        owner_q      <= acc_owner;
        op_q         <= acc_op;
        data_q       <= acc_data;
        err_q        <= acc_err;
        last_grant_q <= acc_owner;
      end

      // Flags are computed from the pre-update count so they stay registered
      // and in step with count.
      if (state_q == S_WRITE) begin
        sp_q    <= sp_q + ADDR_ONE;
        count_q <= count_q + CNT_ONE;
        full_q  <= (count_q == (CNT_FULL - CNT_ONE));
        empty_q <= 1'b0;
      end else if (state_q == S_READ) begin
        sp_q    <= sp_q - ADDR_ONE;
        count_q <= count_q - CNT_ONE;
        full_q  <= 1'b0;
        empty_q <= (count_q == CNT_ONE);
      end
    end
  end

endmodule

// File: tb/tb_stack_access_arbiter.sv
// tb/tb_stack_access_arbiter.sv - scoreboard bench for stack_access_arbiter with a queue-based stack model

module tb_stack_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a_valid, req_a_op, req_a_ready;
  logic [7:0] req_a_data;
  logic       rsp_a_valid, rsp_a_err;
  logic [7:0] rsp_a_data;
  logic       req_b_valid, req_b_op, req_b_ready;
  logic [7:0] req_b_data;
  logic       rsp_b_valid, rsp_b_err;
  logic [7:0] rsp_b_data;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [8:0] count;
  logic       full, empty;

  stack_access_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_op(req_a_op), .req_a_data(req_a_data),
    .req_a_ready(req_a_ready), .rsp_a_valid(rsp_a_valid), .rsp_a_data(rsp_a_data),
    .rsp_a_err(rsp_a_err),
    .req_b_valid(req_b_valid), .req_b_op(req_b_op), .req_b_data(req_b_data),
    .req_b_ready(req_b_ready), .rsp_b_valid(rsp_b_valid), .rsp_b_data(rsp_b_data),
    .rsp_b_err(rsp_b_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Synchronous-read stack memory seen by the DUT.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed { logic op; logic [7:0] data; logic [7:0] gap; } cmd_t;
  typedef struct packed { logic owner; logic [7:0] data; logic err; logic [31:0] due; } exp_t;
  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

  cmd_t       cmd_a[$];
  cmd_t       cmd_b[$];
  exp_t       exp_q[$];
  wr_t        wr_q[$];
  logic [7:0] model_stack[$];
  logic       model_last;   // 0 = A granted last, 1 = B
  logic       pending;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       scramble_a = 1'b0;
  logic       scramble_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic void add_a(input logic op, input logic [7:0] d, input logic [7:0] gap);
    cmd_t c;
    c.op = op; c.data = d; c.gap = gap;
    cmd_a.push_back(c);
  endfunction

  function automatic void add_b(input logic op, input logic [7:0] d, input logic [7:0] gap);
    cmd_t c;
    c.op = op; c.data = d; c.gap = gap;
    cmd_b.push_back(c);
  endfunction

  // Monitor / scoreboard: owns the reference stack and the arbitration rule.
  initial begin : monitor
    exp_t e;
    wr_t  w;
    logic rsp_seen, exp_ra, exp_rb, owner, op;
    logic [7:0] d;
    model_last = 1'b1;
    pending    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        model_stack.delete();
        exp_q.delete();
        wr_q.delete();
        pending    = 1'b0;
        model_last = 1'b1;
      end else begin
        rsp_seen = rsp_a_valid || rsp_b_valid;
        if (rsp_a_valid && rsp_b_valid) note_fail("rsp_both_valid");
        if (rsp_seen) begin
          if (exp_q.size() == 0) begin
            note_fail("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            pending = 1'b0;
            chk("rsp_owner", rsp_b_valid, e.owner);
            chk("rsp_data", e.owner ? rsp_b_data : rsp_a_data, e.data);
            chk("rsp_err", e.owner ? rsp_b_err : rsp_a_err, e.err);
            chk("rsp_other_quiet", e.owner ? {rsp_a_data, rsp_a_err} : {rsp_b_data, rsp_b_err}, 0);
            chk("rsp_latency", cyc, e.due);
          end
        end else if (pending && (cyc > exp_q[0].due)) begin
          note_fail("rsp_timeout");
          e = exp_q.pop_front();
          pending = 1'b0;
        end

        if (!pending) begin
          chk("count", count, model_stack.size());
          chk("full", full, model_stack.size() == 256);
          chk("empty", empty, model_stack.size() == 0);
        end

        if (mem_we) begin
          if (wr_q.size() == 0) begin
            note_fail("unexpected_mem_write");
          end else begin
            w = wr_q.pop_front();
            chk("mem_addr", mem_addr, w.addr);
            chk("mem_wdata", mem_wdata, w.data);
          end
        end

        exp_ra = 1'b0;
        exp_rb = 1'b0;
        if (!pending && !rsp_seen) begin
          exp_ra = req_a_valid && (!req_b_valid || model_last);
          exp_rb = req_b_valid && (!req_a_valid || !model_last);
        end
        chk("req_a_ready", req_a_ready, exp_ra);
        chk("req_b_ready", req_b_ready, exp_rb);

        if (exp_ra || exp_rb) begin
          owner   = exp_rb;
          op      = owner ? req_b_op : req_a_op;
          d       = owner ? req_b_data : req_a_data;
          e.owner = owner;
          e.data  = 8'h00;
          e.err   = 1'b0;
          if (op == 1'b0) begin
            if (model_stack.size() == 256) begin
              e.err = 1'b1;
            end else begin
              w.addr = 8'(model_stack.size());
              w.data = d;
              wr_q.push_back(w);
              model_stack.push_back(d);
            end
          end else begin
            if (model_stack.size() == 0) e.err = 1'b1;
            else e.data = model_stack.pop_back();
          end
          e.due = cyc + (e.err ? 1 : 2);
          exp_q.push_back(e);
          pending    = 1'b1;
          model_last = owner;
        end
      end
    end
  end

  task automatic run_a();
    cmd_t c;
    int   n;
    logic done;
    while (cmd_a.size() > 0) begin
      c = cmd_a.pop_front();
      if (c.gap > 0) begin
        req_a_valid = 1'b0;
        repeat (c.gap) @(posedge clk);
        #1;
      end
      req_a_valid = 1'b1;
      req_a_op    = c.op;
      req_a_data  = c.data;
      n = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (req_a_ready) begin
          done = 1'b1;
        end else if (n > 3000) begin
          note_fail("a_accept_timeout");
          done = 1'b1;
        end else begin
          n++;
          @(posedge clk);
          #1;
          if (scramble_a) req_a_data = 8'($urandom);
        end
      end
      @(posedge clk);
      #1;
    end
    req_a_valid = 1'b0;
  endtask

  task automatic run_b();
    cmd_t c;
    int   n;
    logic done;
    while (cmd_b.size() > 0) begin
      c = cmd_b.pop_front();
      if (c.gap > 0) begin
        req_b_valid = 1'b0;
        repeat (c.gap) @(posedge clk);
        #1;
      end
      req_b_valid = 1'b1;
      req_b_op    = c.op;
      req_b_data  = c.data;
      n = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (req_b_ready) begin
          done = 1'b1;
        end else if (n > 3000) begin
          note_fail("b_accept_timeout");
          done = 1'b1;
        end else begin
          n++;
          @(posedge clk);
          #1;
          if (scramble_b) req_b_data = 8'($urandom);
        end
      end
      @(posedge clk);
      #1;
    end
    req_b_valid = 1'b0;
  endtask

  task automatic run_both();
    fork
      run_a();
      run_b();
    join
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {rsp_a_valid, rsp_b_valid}, 0);
    chk("rst_rsp_err", {rsp_a_err, rsp_b_err}, 0);
    chk("rst_rsp_data", {rsp_a_data, rsp_b_data}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench stalled");
  end

  initial begin : stim
    logic [7:0] last_val;
    logic [7:0] v;
    reset = 1'b1;
    req_a_valid = 1'b0; req_a_op = 1'b0; req_a_data = 8'h00;
    req_b_valid = 1'b0; req_b_op = 1'b0; req_b_data = 8'h00;
    @(posedge clk);
    #1;

    // LIFO order from a single requester.
    do_reset();
    add_a(1'b0, 8'h11, 0);
    add_a(1'b0, 8'h22, 0);
    add_a(1'b1, 8'h00, 0);
    add_a(1'b1, 8'h00, 0);
    run_both();

    // Pop on empty straight after reset.
    do_reset();
    add_b(1'b1, 8'h5A, 0);
    run_both();

    // Contention alternates A,B,... starting with A.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_a(1'b0, 8'hA0 + 8'(i), 0);
      add_b(1'b0, 8'hB0 + 8'(i), 0);
    end
    run_both();
    for (int i = 0; i < 3; i++) begin
      chk("alt_mem_a", mem[2*i], 8'hA0 + 8'(i));
      chk("alt_mem_b", mem[2*i+1], 8'hB0 + 8'(i));
    end

    // A's data moves while B keeps the block busy; acceptance-time value wins.
    scramble_a = 1'b1;
    for (int i = 0; i < 4; i++) add_b(1'b0, 8'($urandom), 0);
    add_a(1'b0, 8'h3C, 1);
    add_a(1'b1, 8'h00, 0);
    add_a(1'b0, 8'hC3, 0);
    run_both();
    scramble_a = 1'b0;

    // Fill to DEPTH, reject one more push, pop the top.
    do_reset();
    last_val = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      add_a(1'b0, v, 0);
      last_val = v;
    end
    run_both();
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_count", count, 256);
    @(posedge clk);
    #1;
    add_b(1'b0, 8'hEE, 0);
    run_both();
    @(negedge clk);
    chk("full_push_count", count, 256);
    @(posedge clk);
    #1;
    add_a(1'b1, 8'h00, 0);
    run_both();
    @(negedge clk);
    chk("pop_after_full", full, 0);
    chk("pop_top_mem", mem[255], last_val);
    @(posedge clk);
    #1;

    // Reset while a push is in its memory-write cycle.
    req_a_valid = 1'b1;
    req_a_op    = 1'b0;
    req_a_data  = 8'h77;
    @(negedge clk);
    chk("rstw_accept", req_a_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_a_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_count", count, 0);
    chk("rstw_empty", empty, 1);
    @(posedge clk);
    #1;
    add_a(1'b0, 8'h99, 0);
    add_a(1'b1, 8'h00, 0);
    run_both();
    chk("rstw_addr0", mem[0], 8'h99);

    // Randomised mixed traffic.
    do_reset();
    scramble_b = 1'b1;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 1) == 1)
        add_a(($urandom_range(0, 9) < 4), 8'($urandom), 8'($urandom_range(0, 3)));
      else
        add_b(($urandom_range(0, 9) < 4), 8'($urandom), 8'($urandom_range(0, 3)));
    end
    run_both();
    scramble_b = 1'b0;

    repeat (4) @(posedge clk);
    chk("leftover_rsp", exp_q.size(), 0);
    chk("leftover_writes", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_access_arbiter.md
Name: stack_access_arbiter

Overview:
- Sequences and shares one synchronous-read stack memory (DEPTH x DATA_W) between two requesters, A and B.
- Each requester issues push or pop operations over a valid/ready handshake.
- The block arbitrates round-robin, runs the memory write/read steps, and maintains the stack pointer and occupancy flags.
- Each requester receives its own one-cycle response pulse, carrying pop data or an error flag.

Parameters:
- DATA_W, 8, width of a stack entry.
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a_valid  in  1  requester A has an operation pending.
- req_a_op  in  1  A operation: 0 = push, 1 = pop.
- req_a_data  in  DATA_W  A push data.
- req_a_ready  out  1  A request accepted this cycle when high together with req_a_valid.
- rsp_a_valid  out  1  one-cycle pulse; A operation complete.
- rsp_a_data  out  DATA_W  pop data for A; 0 for push or error.
- rsp_a_err  out  1  A operation rejected (push when full, pop when empty).
- req_b_valid, req_b_op, req_b_data, req_b_ready, rsp_b_valid, rsp_b_data, rsp_b_err: same as the A ports, for requester B.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values:
  - state = IDLE, sp = 0, count = 0, empty = 1, full = 0.
  - last_grant = B, so A wins the first contention.
  - All rsp_* = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - reset overrides any in-flight operation; that operation is dropped with no response. Memory contents are not cleared.
- State machine: IDLE, WRITE, READ, RESP.
- IDLE:
  - Grant is combinational: if only one requester is valid, it is granted. If both are valid, grant the one not equal to last_grant.
  - req_x_ready = 1 only for the granted requester, and only in IDLE. The other ready = 0.
  - On acceptance: latch owner, op and data, and set last_grant = owner.
  - Push with full=0 -> WRITE. Pop with empty=0 -> READ.
  - Push with full=1, or pop with empty=1 -> RESP with err=1; no memory access, sp unchanged.
- WRITE:
  - mem_we = 1, mem_addr = sp, mem_wdata = latched data.
  - At clock edge: sp <= sp+1, count <= count+1. Next state RESP.
- READ:
  - mem_addr = sp-1 (mod 2**ADDR_W), mem_we = 0.
  - At clock edge: sp <= sp-1, count <= count-1. Next state RESP.
- RESP:
  - rsp_owner_valid = 1 for exactly one cycle.
  - rsp_data = mem_rdata for a successful pop, else 0. rsp_err per the rule above.
  - The non-owner's rsp_* = 0.
  - Next state IDLE.
- Latency, accept at cycle T:
  - Success: memory access at T+1, response at T+2, next acceptance possible at T+3.
  - Error: response at T+1, next acceptance at T+2.
- sp is ADDR_W bits and wraps naturally. At full, sp == 0 (mod DEPTH) and count == DEPTH; full and empty are derived from count, never from sp.
- count, full and empty are registered and reflect completed WRITE/READ steps.
- Requester inputs are sampled only at acceptance. Changes while not ready are ignored.
- A requester may hold valid across its own response; it is re-arbitrated in the next IDLE.

Test Plan:
- Reset, then A pushes 0x11, 0x22, then pops twice -> rsp_a_data 0x22 then 0x11, err=0; count goes 1,2,1,0; empty=1 at end; response 2 cycles after each accept.
- Pop on empty from B right after reset -> rsp_b_valid with err=1, data=0 one cycle after accept; count stays 0; mem_we never asserted.
- A and B both hold valid push requests (A=0xA0.., B=0xB0..) for 6 operations -> grants alternate A,B,A,B,A,B starting with A; memory addresses 0..5 receive A0,B0,A1,B1,A2,B2.
- Fill all 256 entries via A -> full=1, count=256; a further push from B gives err=1 and count is unchanged; one pop returns the last value pushed and clears full.
- Assert reset during the WRITE state of a push -> no rsp pulse, sp=0, count=0; the next push writes address 0.
- Change req_a_data while req_a_ready=0 (B busy) -> the value present at acceptance is the one written.
